// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter.
// Two requesters (writeback and debug/load) share one register-file write
// port. Arbitration is round-robin on ties, a write to index 0 is swallowed,
// and the winning request is presented on registered rf_* outputs one cycle
// after acceptance.
//
// Handshake: a transfer happens in any cycle where valid and ready are both
// high. Ready never looks at the requester's own valid, so a requester that
// sees ready low must hold valid, rd and data stable until it is accepted.
//
// Optional feature macro: REGFILE_CLEAR_EN. When defined, reset enters a
// CLEAR state that writes zero to indices 1..2**ADDR_W-1, one per cycle,
// with busy high and both readies low. When undefined, busy is tied low and
// requests are accepted from the first cycle after reset.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              dbg_valid,
  input  logic [ADDR_W-1:0] dbg_rd,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);

  // High when the debug requester won the most recent transfer; reset value
  // (0 = writeback last) lets debug win the first tie.
  logic              last_dbg;
  logic              run;
  logic              wb_fire;
  logic              dbg_fire;
  logic              fire;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

`ifdef REGFILE_CLEAR_EN
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;

  assign run  = (state == RUN);
  assign busy = (state == CLEAR);
`else
  assign run  = 1'b1;
  assign busy = 1'b0;
`endif

  // Each ready is blocked only by the other requester holding the grant
  // priority, so it is independent of the requester's own valid.
  assign wb_ready  = rst_n & run & (~dbg_valid | last_dbg);
  assign dbg_ready = rst_n & run & (~wb_valid | ~last_dbg);

  assign wb_fire  = wb_valid & wb_ready;
  assign dbg_fire = dbg_valid & dbg_ready;
  assign fire     = wb_fire | dbg_fire;

  // At most one side can fire, so the mux select only needs dbg_fire.
  assign sel_rd   = dbg_fire ? dbg_rd : wb_rd;
  assign sel_data = dbg_fire ? dbg_data : wb_data;

  // State, clear counter, grant pointer and registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      last_dbg <= 1'b0;
`ifdef REGFILE_CLEAR_EN
      state    <= CLEAR;
      clr_idx  <= {{(ADDR_W-1){1'b0}}, 1'b1};
`endif
    end else begin
      rf_we <= 1'b0;
`ifdef REGFILE_CLEAR_EN
      if (state == CLEAR) begin
        rf_we    <= 1'b1;
        rf_waddr <= clr_idx;
        rf_wdata <= '0;
        clr_idx  <= clr_idx + 1'b1;
        // Last index reached: the counter wraps and arbitration starts.
        if (&clr_idx) begin
          state <= RUN;
        end
      end
`endif
      // Readies are low outside RUN, so fire cannot collide with clearing.
      if (fire) begin
        rf_we    <= (sel_rd != '0);
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
        last_dbg <= dbg_fire;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed scenarios followed by
// randomized traffic, scored against a transaction-level reference model.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
`ifdef REGFILE_CLEAR_EN
  localparam int NCLR = (1 << ADDR_W) - 1;
`else
  localparam int NCLR = 0;
`endif

  logic              clk;
  logic              rst_n;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              dbg_valid;
  logic [ADDR_W-1:0] dbg_rd;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .dbg_valid (dbg_valid),
    .dbg_rd    (dbg_rd),
    .dbg_data  (dbg_data),
    .dbg_ready (dbg_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Kept as transactions: who was granted last, how many clear writes are
  // left, and which write the port owes us next cycle.
  bit                m_init      = 0;
  bit                m_rst_prev  = 0;
  bit                m_we        = 0;
  string             m_last      = "wb";
  int                m_clear_left = 0;
  int                m_clear_idx  = 1;
  logic [1:0]        last_grant;   // 0 none, 1 wb, 2 dbg
  bit                g_wb, g_dbg;

  // One clock cycle: check outputs at the negedge, advance the model,
  // then return 1 time unit after the next rising edge.
  task automatic step();
    logic [ADDR_W+DATA_W-1:0] item;
    logic [ADDR_W-1:0]        rd;
    logic [DATA_W-1:0]        data;
    @(negedge clk);
    g_wb = 0;
    g_dbg = 0;
    if (m_init) begin
      check("rf_we", rf_we, m_we);
      if (m_rst_prev) begin
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
      end
      if (rf_we === 1'b1) begin
        if (exp_q.size() > 0) begin
          item = exp_q.pop_front();
          check("rf_waddr", rf_waddr, item[ADDR_W+DATA_W-1:DATA_W]);
          check("rf_wdata", rf_wdata, item[DATA_W-1:0]);
        end else begin
          check("sb_unexpected_write", 1, 0);
        end
      end
    end
    if (!rst_n) begin
      check("rst_wb_ready", wb_ready, 0);
      check("rst_dbg_ready", dbg_ready, 0);
      m_we = 0;
      m_last = "wb";
      m_clear_left = NCLR;
      m_clear_idx = 1;
      exp_q.delete();
      m_init = 1;
      m_rst_prev = 1;
    end else begin
      m_rst_prev = 0;
      if (m_clear_left > 0) begin
        check("clr_busy", busy, 1);
        check("clr_wb_ready", wb_ready, 0);
        check("clr_dbg_ready", dbg_ready, 0);
        exp_q.push_back({ADDR_W'(m_clear_idx), DATA_W'(0)});
        m_we = 1;
        m_clear_idx++;
        m_clear_left--;
      end else begin
        check("run_busy", busy, 0);
        if (wb_valid && dbg_valid) begin
          g_dbg = (m_last == "wb");
          g_wb  = !g_dbg;
        end else begin
          g_wb  = wb_valid;
          g_dbg = dbg_valid;
        end
        if (wb_valid)  check("wb_ready", wb_ready, g_wb);
        if (dbg_valid) check("dbg_ready", dbg_ready, g_dbg);
        if (g_wb || g_dbg) begin
          rd   = g_dbg ? dbg_rd : wb_rd;
          data = g_dbg ? dbg_data : wb_data;
          m_we = (rd != 0);
          if (m_we) exp_q.push_back({rd, data});
          m_last = g_dbg ? "dbg" : "wb";
        end else begin
          m_we = 0;
        end
      end
    end
    last_grant = g_dbg ? 2'd2 : (g_wb ? 2'd1 : 2'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    wb_valid = 0; dbg_valid = 0;
    wb_rd = '0; dbg_rd = '0; wb_data = '0; dbg_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    repeat (NCLR) step();
  endtask

  // New request only once the previous one was taken (or none was pending).
  task automatic drive_random();
    if (!wb_valid || g_wb) begin
      wb_valid = ($urandom_range(0, 3) != 0);
      wb_rd    = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
      wb_data  = $urandom;
    end
    if (!dbg_valid || g_dbg) begin
      dbg_valid = ($urandom_range(0, 2) != 0);
      dbg_rd    = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
      dbg_data  = $urandom;
    end
    rst_n = ($urandom_range(0, 299) != 0);
  endtask

  // ---------------- test sequence ----------------
  logic [1:0] exp_g [4] = '{2'd2, 2'd1, 2'd2, 2'd1};

  initial begin
    rst_n = 0;
    idle();

    // Reset, holding wb_valid through any clear phase: no acceptance until busy drops.
    wb_valid = 1; wb_rd = 5'd7; wb_data = 32'h0BAD_F00D;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
    repeat (NCLR) step();
    step();
    check("first_accept_grant", last_grant, 1);
    idle();
    step();

`ifdef REGFILE_CLEAR_EN
    // Reset in the middle of the clear: restart from index 1.
    rst_n = 0;
    step();
    rst_n = 1;
    repeat (9) step();
    rst_n = 0;
    step();
    check("midclr_rf_we", rf_we, 0);
    rst_n = 1;
    step();
    check("midclr_restart_idx", rf_waddr, 1);
    repeat (NCLR - 1) step();
`endif

    // Single writeback accepted, data appears next cycle.
    do_reset();
    wb_valid = 1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    step();
    check("single_grant", last_grant, 1);
    check("single_we", rf_we, 1);
    check("single_waddr", rf_waddr, 5);
    check("single_wdata", rf_wdata, 32'hDEAD_BEEF);
    idle();
    step();
    check("single_we_drop", rf_we, 0);

    // Both valid continuously: alternating grants starting with debug.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1; wb_rd = ADDR_W'(i + 1); wb_data = 32'h1000 + i;
      dbg_valid = 1; dbg_rd = ADDR_W'(i + 10); dbg_data = 32'h2000 + i;
      step();
      check("rr_grant", last_grant, exp_g[i]);
      check("rr_we", rf_we, 1);
    end
    idle();
    step();

    // Write to index 0: handshake completes, no register write, pointer moves.
    do_reset();
    wb_valid = 1; wb_rd = '0; wb_data = 32'h1234;
    step();
    check("x0_grant", last_grant, 1);
    check("x0_we", rf_we, 0);
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h55;
    dbg_valid = 1; dbg_rd = 5'd4; dbg_data = 32'h66;
    step();
    check("x0_tie_grant", last_grant, 2);
    idle();
    step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      drive_random();
      step();
    end

    rst_n = 1;
    idle();
    repeat (NCLR + 2) step();
    check("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; register count is 2**ADDR_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wb_valid  input  1  writeback requester has a write pending.
REQ-006 SHALL have port wb_rd  input  ADDR_W  writeback destination index.
REQ-007 SHALL have port wb_data  input  DATA_W  writeback data.
REQ-008 SHALL have port wb_ready  output  1  writeback request accepted this cycle.
REQ-009 SHALL have port dbg_valid  input  1  debug/load requester has a write pending.
REQ-010 SHALL have port dbg_rd  input  ADDR_W  debug destination index.
REQ-011 SHALL have port dbg_data  input  DATA_W  debug data.
REQ-012 SHALL have port dbg_ready  output  1  debug request accepted this cycle.
REQ-013 SHALL have port rf_we  output  1  register-file write enable (registered).
REQ-014 SHALL have port rf_waddr  output  ADDR_W  register-file write index (registered).
REQ-015 SHALL have port rf_wdata  output  DATA_W  register-file write data (registered).
REQ-016 SHALL have port busy  output  1  high while the clear sequence runs.

Function
REQ-017 SHALL implement states CLEAR and RUN; CLEAR exists only with REGFILE_CLEAR_EN.
REQ-018 A transfer SHALL occur when valid and ready are both high in one cycle; ready is combinational from state, valid inputs and grant pointer.
REQ-019 In RUN, one requester only SHALL be granted per cycle; if both are valid, grant goes to the one not granted last (round-robin); if one is valid, it is granted.
REQ-020 Grant pointer SHALL update only on a completed transfer; pointer resets to "wb last granted" (debug wins the first tie).
REQ-021 An accepted transfer SHALL appear on rf_we/rf_waddr/rf_wdata exactly one cycle later, for exactly one cycle.
REQ-022 An accepted transfer with rd == 0 SHALL complete the handshake and move the pointer, but rf_we SHALL stay 0 that cycle.
REQ-023 With no transfer, rf_we SHALL be 0 next cycle; rf_waddr/rf_wdata hold their previous values.
REQ-024 Ready SHALL not depend on the requester's own valid input; a requester that is not ready SHALL hold valid, rd and data stable until accepted.
REQ-025 In CLEAR, wb_ready and dbg_ready SHALL be 0, busy SHALL be 1, and a 5-bit counter SHALL issue writes of 0 to indices 1..2**ADDR_W-1, one per cycle.
REQ-026 Counter wrap-around: after issuing index 2**ADDR_W-1, the state SHALL move to RUN, with busy low from the next cycle; the clear takes 2**ADDR_W-1 cycles.

Reset
REQ-027 While rst_n is low at a clock edge, rf_we, rf_waddr, rf_wdata and both ready outputs SHALL be 0, the pointer SHALL reset, and the clear counter SHALL be 1.
REQ-028 After reset, the state SHALL be CLEAR (macro defined) or RUN (macro undefined); busy is 1 or 0 accordingly.
REQ-029 Reset asserted mid-clear or mid-transfer SHALL abort it; the pending registered write SHALL not be issued and the clear restarts from index 1.

Configuration
REQ-030 Macro REGFILE_CLEAR_EN defined: CLEAR state, counter and clear writes are compiled in, per REQ-025/026.
REQ-031 REGFILE_CLEAR_EN undefined: no CLEAR logic exists, busy SHALL be tied 0, and requests are accepted from the first cycle after reset.

Verification
REQ-032 wb_valid=1, rd=5, data=0xDEADBEEF, dbg idle -> wb_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-033 Both valid continuously for 4 cycles after reset -> grants dbg, wb, dbg, wb; rf_we high 4 consecutive cycles.
REQ-034 wb_valid=1, rd=0, data=0x1234 -> wb_ready=1; next cycle rf_we=0; the following tie grants dbg.
REQ-035 With REGFILE_CLEAR_EN, release reset, hold wb_valid=1 -> busy=1 and wb_ready=0 for 31 cycles, with zero writes to x1..x31 in order; then busy=0 and wb accepted.
REQ-036 Assert rst_n=0 at clear index 10, then release -> clear restarts at index 1; no write issued during reset cycle.
